idli_sqi_mem: RTL and testbench



---
 rtl/idli_pkg.sv | 10 +
 rtl/idli_sqi_mem.sv | 132 +++++++++++++
 tb/tb_idli_sqi_mem.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/idli_pkg.sv
// Types and constants shared between the idli core and its external memory models.
package idli_pkg;

    typedef logic [3:0] slice_t;

    // Instruction bytes understood by the serial SRAM in sequential mode.
    localparam logic [7:0] SQI_OP_READ  = 8'h03;
    localparam logic [7:0] SQI_OP_WRITE = 8'h02;

endpackage

// File: rtl/idli_sqi_mem.sv
// Behavioural model of a byte-addressed quad-SPI serial SRAM (sequential mode only),
// used as the low/high external memory of the idli core. Preload data_q hierarchically.
//
// state  | meaning
// -------+-----------------------------------------------------------
// CMD    | receiving the instruction byte (edges 0-1)
// ADDR   | receiving the address nibbles, high nibble first
// DUMMY  | two dummy edges of a READ; high nibble of first byte loads on the last
// RDATA  | streaming read data, one nibble per edge, address auto-increments
// WDATA  | assembling write bytes from nibble pairs, committing on the low nibble
// IGNORE | unknown instruction; idle until deselect
import idli_pkg::*;

module idli_sqi_mem #(
    parameter int DEPTH  = 131072,
    parameter int ADDR_W = 24
) (
    input  logic   i_sqi_sck,
    input  logic   i_sqi_rst,
    input  logic   i_sqi_cs,
    input  slice_t i_sqi_sio,
    output slice_t o_sqi_sio
);

    localparam int IDX_W    = $clog2(DEPTH);
    localparam int ADDR_NIB = ADDR_W / 4;
    localparam int CNT_W    = $clog2(ADDR_NIB + 6);

    typedef enum logic [2:0] {
        CMD,
        ADDR,
        DUMMY,
        RDATA,
        WDATA,
        IGNORE
    } state_t;

    logic [7:0]       data_q [DEPTH];

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] idx_q;
    slice_t           cmd_hi_q;
    slice_t           hi_q;
    logic             rd_q;
    slice_t           sio_q;
    logic [7:0]       cmd_byte;
    logic             wr_commit;

    assign cmd_byte  = {cmd_hi_q, i_sqi_sio};
    assign o_sqi_sio = sio_q;

    // Deselect and reset share one path so a data edge coinciding with either is dropped.
    assign wr_commit = !i_sqi_rst && !i_sqi_cs && (state_q == WDATA) && cnt_q[0];

    always_ff @(posedge i_sqi_sck) begin
        if (i_sqi_rst || i_sqi_cs) begin
            state_q <= CMD;
            cnt_q   <= '0;
            sio_q   <= '0;
        end else begin
            sio_q <= '0;
            case (state_q)
                CMD: begin
                    if (cnt_q == '0) begin
                        cmd_hi_q <= i_sqi_sio;
                        cnt_q    <= CNT_W'(1);
                    end else begin
                        cnt_q <= CNT_W'(2);
                        if (cmd_byte == SQI_OP_READ) begin
                            rd_q    <= 1'b1;
                            state_q <= ADDR;
                        end else if (cmd_byte == SQI_OP_WRITE) begin
                            rd_q    <= 1'b0;
                            state_q <= ADDR;
                        end else begin
                            state_q <= IGNORE;
                        end
                    end
                end
                ADDR: begin
                    // Bits above IDX_W fall off the top, giving address mod DEPTH.
                    idx_q <= IDX_W'({idx_q, i_sqi_sio});
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(ADDR_NIB + 1)) begin
                        state_q <= rd_q ? DUMMY : WDATA;
                    end
                end
                DUMMY: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(ADDR_NIB + 3)) begin
                        sio_q   <= data_q[idx_q][7:4];
                        state_q <= RDATA;
                    end
                end
                RDATA: begin
                    // Edge parity selects the nibble: even edges finish a byte.
                    cnt_q <= {cnt_q[CNT_W-1:1], ~cnt_q[0]};
                    if (!cnt_q[0]) begin
                        sio_q <= data_q[idx_q][3:0];
                        idx_q <= idx_q + IDX_W'(1);
                    end else begin
                        sio_q <= data_q[idx_q][7:4];
                    end
                end
                WDATA: begin
                    cnt_q <= {cnt_q[CNT_W-1:1], ~cnt_q[0]};
                    if (!cnt_q[0]) begin
                        hi_q <= i_sqi_sio;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                IGNORE: begin
                    state_q <= IGNORE;
                end
                default: begin
                    state_q <= CMD;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Storage is deliberately left out of reset so preloaded contents survive.
    always_ff @(posedge i_sqi_sck) begin
        if (wr_commit) begin
            data_q[idx_q] <= {hi_q, i_sqi_sio};
        end
    end

endmodule

// File: tb/tb_idli_sqi_mem.sv
// Directed bench for idli_sqi_mem: read, write, wrap, abort, unknown opcode, address aliasing.
import idli_pkg::*;

module tb_idli_sqi_mem;

    localparam int DEPTH = 131072;

    logic   sck = 1'b0;
    logic   rst = 1'b1;
    logic   cs  = 1'b1;
    slice_t sio = '0;
    slice_t sio_out;

    int n_vec = 0;
    int n_err = 0;

    idli_sqi_mem #(.DEPTH(DEPTH), .ADDR_W(24)) dut (
        .i_sqi_sck (sck),
        .i_sqi_rst (rst),
        .i_sqi_cs  (cs),
        .i_sqi_sio (sio),
        .o_sqi_sio (sio_out)
    );

    always #5 sck = ~sck;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Drive one nibble with cs low; return just after the rising edge that samples it.
    task automatic nib(input slice_t n);
        @(negedge sck);
        cs  = 1'b0;
        sio = n;
        @(posedge sck);
        #1;
    endtask

    task automatic deselect();
        @(negedge sck);
        cs  = 1'b1;
        sio = '0;
        @(posedge sck);
        #1;
    endtask

    task automatic hdr(input logic [7:0] op, input logic [23:0] a);
        nib(op[7:4]);
        nib(op[3:0]);
        for (int i = 5; i >= 0; i--) nib(a[i*4 +: 4]);
    endtask

    // READ two bytes at a and compare four output nibbles against exp, MSB first.
    task automatic rd4(input string tag, input logic [23:0] a, input logic [15:0] exp);
        hdr(8'h03, a);
        nib(4'h0);
        chk({tag, "_dummy"}, 8'(sio_out), 8'h00);
        nib(4'h0);
        chk({tag, "_n0"}, 8'(sio_out), 8'(exp[15:12]));
        for (int k = 2; k >= 0; k--) begin
            nib(4'h0);
            chk($sformatf("%s_n%0d", tag, 3 - k), 8'(sio_out), 8'(exp[k*4 +: 4]));
        end
        deselect();
        chk({tag, "_idle"}, 8'(sio_out), 8'h00);
    endtask

    initial begin
        dut.data_q[32'h10]      = 8'hA5;
        dut.data_q[32'h11]      = 8'h3C;
        dut.data_q[32'h20]      = 8'h55;
        dut.data_q[DEPTH-1]     = 8'hEE;
        dut.data_q[0]           = 8'h77;

        repeat (2) @(posedge sck);
        #1;
        chk("reset_out", 8'(sio_out), 8'h00);
        @(negedge sck);
        rst = 1'b0;

        rd4("rd_10", 24'h000010, 16'hA53C);

        hdr(8'h02, 24'h000100);
        nib(4'h1);
        nib(4'h2);
        chk("wr_out", 8'(sio_out), 8'h00);
        nib(4'h3);
        nib(4'h4);
        deselect();
        chk("wr_mem100", dut.data_q[32'h100], 8'h12);
        chk("wr_mem101", dut.data_q[32'h101], 8'h34);
        rd4("rd_100", 24'h000100, 16'h1234);

        rd4("rd_wrap", 24'(DEPTH - 1), 16'hEE77);

        hdr(8'h02, 24'(DEPTH - 1));
        nib(4'hA); nib(4'hB); nib(4'hC); nib(4'hD);
        deselect();
        chk("wrw_top", dut.data_q[DEPTH-1], 8'hAB);
        chk("wrw_zero", dut.data_q[0], 8'hCD);

        // Abort by cs on the edge that would carry the low nibble.
        hdr(8'h02, 24'h000020);
        nib(4'h9);
        @(negedge sck);
        cs  = 1'b1;
        sio = 4'h8;
        @(posedge sck);
        #1;
        chk("abort_cs_mem", dut.data_q[32'h20], 8'h55);
        chk("abort_cs_out", 8'(sio_out), 8'h00);

        // Same again with reset while cs stays low.
        hdr(8'h02, 24'h000020);
        nib(4'h9);
        @(negedge sck);
        rst = 1'b1;
        sio = 4'h8;
        @(posedge sck);
        #1;
        chk("abort_rst_out", 8'(sio_out), 8'h00);
        @(negedge sck);
        rst = 1'b0;
        deselect();
        chk("abort_rst_mem", dut.data_q[32'h20], 8'h55);

        // Unknown opcode followed by nibbles that would form a WRITE to 0x10 if misdecoded.
        nib(4'hF);
        nib(4'hF);
        begin
            logic [39:0] junk;
            junk = 40'h00001_0ABCD;
            for (int i = 9; i >= 0; i--) begin
                nib(junk[i*4 +: 4]);
                chk($sformatf("ign_out%0d", 9 - i), 8'(sio_out), 8'h00);
            end
        end
        deselect();
        chk("ign_mem10", dut.data_q[32'h10], 8'hA5);
        chk("ign_mem11", dut.data_q[32'h11], 8'h3C);
        rd4("rd_after_ign", 24'h000010, 16'hA53C);

        rd4("rd_alias", 24'h020010, 16'hA53C);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
